// File: rtl/mfa_tracker_pkg.sv
// Shared types for the MFA tracker: FSM state encoding and the default table-entry layout.
package pkg_en;

  typedef enum logic [1:0] {StIdle, StAccum, StScan, StOut} state_e;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_LENGTH = 256;
  localparam int unsigned DEF_CNT_W  = $clog2(DEF_LENGTH) + 1;

  // Entry layout at the default widths; the tracker re-declares the same shape at its own widths.
  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] value;
    logic [DEF_CNT_W-1:0] count;
  } entry_t;

endpackage

// File: rtl/mfa_argmin.sv
// Combinational lowest-index argmin over table counts, plus lowest free-slot detection.
module mfa_argmin #(
  parameter  int unsigned NUM_ENTRY = 8,
  parameter  int unsigned CNT_W     = 9,
  localparam int unsigned IDX_W     = $clog2(NUM_ENTRY)
) (
  input  logic [NUM_ENTRY-1:0]            valid,
  input  logic [NUM_ENTRY-1:0][CNT_W-1:0] counts,
  output logic [IDX_W-1:0]                min_idx,
  output logic                            has_free,
  output logic [IDX_W-1:0]                free_idx
);

  logic [CNT_W-1:0] min_cnt;

  always_comb begin
    min_idx  = '0;
    min_cnt  = counts[0];
    has_free = 1'b0;
    free_idx = '0;
    // Strict compare keeps the lowest index on ties.
    for (int unsigned i = 1; i < NUM_ENTRY; i++) begin
      if (counts[i] < min_cnt) begin
        min_cnt = counts[i];
        min_idx = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      if (!valid[i] && !has_free) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mfa_tracker.sv
// MFA tracker: Space-Saving (value, count) table over one block, then a linear scan for the winner.
// Build macro MFA_ZERO_SKIP_EN routes zero samples to a dedicated saturating counter.
module mfa_tracker import pkg_en::*; #(
  parameter  int unsigned WIDTH     = DEF_WIDTH,
  parameter  int unsigned NUM_ENTRY = 8,
  parameter  int unsigned LENGTH    = DEF_LENGTH,
  localparam int unsigned CNT_W     = $clog2(LENGTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             I_En,
  input  logic             I_Valid,
  output logic             O_Ready,
  input  logic [WIDTH-1:0] I_Data,
  input  logic             I_Last,
  input  logic             I_Rls,
  input  logic             I_Rd_MFA,
  output logic             O_Valid,
  output logic [WIDTH-1:0] O_SharedData,
  output logic [CNT_W-1:0] O_CountVal,
  output logic             O_Exact,
  output logic [CNT_W-1:0] O_ZeroCount
);

  localparam int unsigned      IDX_W = $clog2(NUM_ENTRY);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LENGTH);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] value;
    logic [CNT_W-1:0] count;
  } ent_t;

  state_e           state_q;
  ent_t             tbl_q [NUM_ENTRY];
  logic [CNT_W-1:0] nsamp_q, nsamp_nxt, best_cnt_q, cnt_q, scan_cnt, hit_cnt, min_cnt;
  logic [WIDTH-1:0] best_val_q, data_q;
  logic [IDX_W:0]   scan_idx_q;
  logic             evicted_q, valid_q, exact_q;
  logic             accept, tbl_upd, blk_end, clear_all, load_out, hit, has_free;
  logic [IDX_W-1:0] hit_idx, free_idx, min_idx;
  logic [NUM_ENTRY-1:0]            valid_vec;
  logic [NUM_ENTRY-1:0][CNT_W-1:0] cnt_vec;

  assign O_Ready   = (state_q == StIdle) || (state_q == StAccum);
  assign accept    = I_En & I_Valid & O_Ready;
  assign nsamp_nxt = nsamp_q + 1'b1;
  assign blk_end   = I_Last || (nsamp_nxt == LEN_C);
  assign clear_all = I_Rls || ((state_q == StOut) && I_Rd_MFA);
  assign load_out  = (state_q == StScan) && (scan_idx_q == (IDX_W+1)'(NUM_ENTRY));
  assign scan_cnt  = tbl_q[scan_idx_q[IDX_W-1:0]].valid ? tbl_q[scan_idx_q[IDX_W-1:0]].count : '0;
  assign hit_cnt   = tbl_q[hit_idx].count;
  assign min_cnt   = tbl_q[min_idx].count;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      valid_vec[i] = tbl_q[i].valid;
      cnt_vec[i]   = tbl_q[i].count;
      if (tbl_q[i].valid && (tbl_q[i].value == I_Data) && !hit) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  mfa_argmin #(
    .NUM_ENTRY(NUM_ENTRY),
    .CNT_W    (CNT_W)
  ) u_argmin (
    .valid   (valid_vec),
    .counts  (cnt_vec),
    .min_idx (min_idx),
    .has_free(has_free),
    .free_idx(free_idx)
  );

`ifdef MFA_ZERO_SKIP_EN
  logic [CNT_W-1:0] zc_q, zc_out_q;

  assign tbl_upd     = accept && (I_Data != '0);
  assign O_ZeroCount = zc_out_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      zc_q     <= '0;
      zc_out_q <= '0;
    end else if (clear_all) begin
      zc_q     <= '0;
      zc_out_q <= '0;
    end else begin
      if (accept && (I_Data == '0) && (zc_q != LEN_C)) zc_q <= zc_q + 1'b1;
      if (load_out) zc_out_q <= zc_q;
    end
  end
`else
  assign tbl_upd     = accept;
  assign O_ZeroCount = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      for (int unsigned i = 0; i < NUM_ENTRY; i++) tbl_q[i] <= '0;
      nsamp_q    <= '0;
      evicted_q  <= 1'b0;
      scan_idx_q <= '0;
      best_cnt_q <= '0;
      best_val_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      exact_q    <= 1'b0;
    end else if (clear_all) begin
      // Release, or acknowledge in OUT: drop the block and return every output to 0.
      state_q    <= StIdle;
      for (int unsigned i = 0; i < NUM_ENTRY; i++) tbl_q[i] <= '0;
      nsamp_q    <= '0;
      evicted_q  <= 1'b0;
      scan_idx_q <= '0;
      best_cnt_q <= '0;
      best_val_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      exact_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            nsamp_q <= nsamp_nxt;
            if (tbl_upd) begin
              if (hit) begin
                tbl_q[hit_idx].count <= (hit_cnt == LEN_C) ? hit_cnt : hit_cnt + 1'b1;
              end else if (has_free) begin
                tbl_q[free_idx] <= '{valid: 1'b1, value: I_Data, count: CNT_W'(1)};
              end else begin
                tbl_q[min_idx] <= '{valid: 1'b1, value: I_Data,
                                    count: (min_cnt == LEN_C) ? min_cnt : min_cnt + 1'b1};
                evicted_q      <= 1'b1;
              end
            end
            if (blk_end) begin
              state_q    <= StScan;
              scan_idx_q <= '0;
              best_cnt_q <= '0;
              best_val_q <= '0;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StScan: begin
          if (load_out) begin
            state_q <= StOut;
            valid_q <= 1'b1;
            data_q  <= best_val_q;
            cnt_q   <= best_cnt_q;
            exact_q <= ~evicted_q;
          end else begin
            // Strictly-greater replace leaves ties with the lowest index.
            if (scan_cnt > best_cnt_q) begin
              best_cnt_q <= scan_cnt;
              best_val_q <= tbl_q[scan_idx_q[IDX_W-1:0]].value;
            end
            scan_idx_q <= scan_idx_q + 1'b1;
          end
        end
        StOut: state_q <= StOut;
      endcase
    end
  end

  assign O_Valid      = valid_q;
  assign O_SharedData = data_q;
  assign O_CountVal   = cnt_q;
  assign O_Exact      = exact_q;

endmodule

// File: tb/tb_mfa_tracker.sv
// Bench for mfa_tracker: two instances (8 entries/256 samples, 4 entries/16 samples) checked against
// a frequency-table model every cycle, plus literal expectations per block. Honours MFA_ZERO_SKIP_EN.
module tb_mfa_tracker;

  logic        clock = 1'b0;
  logic        reset, en_a, en_b, valid, last, rls, rd;
  logic [31:0] data;
  logic        rdy_a, vld_a, ex_a, rdy_b, vld_b, ex_b;
  logic [31:0] sd_a, sd_b;
  logic [8:0]  cv_a, zc_a;
  logic [4:0]  cv_b, zc_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mfa_tracker #(.WIDTH(32), .NUM_ENTRY(8), .LENGTH(256)) dut_a (
    .clock(clock), .reset(reset), .I_En(en_a), .I_Valid(valid), .O_Ready(rdy_a), .I_Data(data),
    .I_Last(last), .I_Rls(rls), .I_Rd_MFA(rd), .O_Valid(vld_a), .O_SharedData(sd_a),
    .O_CountVal(cv_a), .O_Exact(ex_a), .O_ZeroCount(zc_a)
  );

  mfa_tracker #(.WIDTH(32), .NUM_ENTRY(4), .LENGTH(16)) dut_b (
    .clock(clock), .reset(reset), .I_En(en_b), .I_Valid(valid), .O_Ready(rdy_b), .I_Data(data),
    .I_Last(last), .I_Rls(rls), .I_Rd_MFA(rd), .O_Valid(vld_b), .O_SharedData(sd_b),
    .O_CountVal(cv_b), .O_Exact(ex_b), .O_ZeroCount(zc_b)
  );

  // Model: phase 0 = taking samples, 1 = scanning (m_sc cycles left), 2 = result presented.
  int          ne  [2] = '{8, 4};
  int          len [2] = '{256, 16};
  int          m_ph [2], m_sc [2], m_ns [2], m_zc [2];
  bit          m_ev [2];
  bit          m_tv   [2][8];
  logic [31:0] m_tval [2][8];
  int          m_tcnt [2][8];
  bit          m_ov [2], m_oe [2];
  logic [31:0] m_od [2];
  int          m_oc [2], m_oz [2];
  int          q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_clear(input int d);
    m_ph[d] = 0; m_sc[d] = 0; m_ns[d] = 0; m_zc[d] = 0; m_ev[d] = 0;
    for (int i = 0; i < 8; i++) begin
      m_tv[d][i] = 0; m_tval[d][i] = 0; m_tcnt[d][i] = 0;
    end
    m_ov[d] = 0; m_oe[d] = 0; m_od[d] = 0; m_oc[d] = 0; m_oz[d] = 0;
  endtask

  task automatic absorb(input int d, input logic [31:0] v);
    int slot;
`ifdef MFA_ZERO_SKIP_EN
    if (v == 0) begin
      if (m_zc[d] < len[d]) m_zc[d]++;
      return;
    end
`endif
    for (int i = 0; i < ne[d]; i++)
      if (m_tv[d][i] && m_tval[d][i] == v) begin
        if (m_tcnt[d][i] < len[d]) m_tcnt[d][i]++;
        return;
      end
    for (int i = 0; i < ne[d]; i++)
      if (!m_tv[d][i]) begin
        m_tv[d][i] = 1; m_tval[d][i] = v; m_tcnt[d][i] = 1;
        return;
      end
    slot = 0;
    for (int i = 1; i < ne[d]; i++) if (m_tcnt[d][i] < m_tcnt[d][slot]) slot = i;
    m_tval[d][slot] = v;
    m_tcnt[d][slot]++;
    m_ev[d] = 1;
  endtask

  task automatic publish(input int d);
    int best;
    best = 0;
    for (int i = 0; i < ne[d]; i++) if (m_tv[d][i] && m_tcnt[d][i] > best) best = m_tcnt[d][i];
    m_od[d] = 0;
    for (int i = ne[d] - 1; i >= 0; i--)
      if (best > 0 && m_tv[d][i] && m_tcnt[d][i] == best) m_od[d] = m_tval[d][i];
    m_oc[d] = best; m_ov[d] = 1; m_oe[d] = !m_ev[d]; m_oz[d] = m_zc[d];
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!reset || rls) model_clear(d);
      else if (m_ph[d] == 0) begin
        if (((d == 0) ? en_a : en_b) && valid) begin
          absorb(d, data);
          m_ns[d]++;
          if (last || m_ns[d] == len[d]) begin
            m_ph[d] = 1; m_sc[d] = ne[d] + 1;
          end
        end
      end else if (m_ph[d] == 1) begin
        m_sc[d]--;
        if (m_sc[d] == 0) begin
          publish(d); m_ph[d] = 2;
        end
      end else if (rd) model_clear(d);
    end
  endtask

  always @(negedge clock) begin
    check("a_ready", rdy_a, m_ph[0] == 0);
    check("a_valid", vld_a, m_ov[0]);
    check("a_data",  sd_a,  m_od[0]);
    check("a_count", cv_a,  m_oc[0]);
    check("a_exact", ex_a,  m_oe[0]);
    check("a_zero",  zc_a,  m_oz[0]);
    check("b_ready", rdy_b, m_ph[1] == 0);
    check("b_valid", vld_b, m_ov[1]);
    check("b_data",  sd_b,  m_od[1]);
    check("b_count", cv_b,  m_oc[1]);
    check("b_exact", ex_b,  m_oe[1]);
    check("b_zero",  zc_b,  m_oz[1]);
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic send(input int d, input logic [31:0] v, input bit lst);
    en_a = (d == 0); en_b = (d == 1); valid = 1; data = v; last = lst;
    tick();
    en_a = 0; en_b = 0; valid = 0; last = 0; data = 0;
  endtask

  task automatic send_q(input int d, input bit with_last);
    for (int i = 0; i < q.size(); i++) send(d, q[i], with_last && (i == q.size() - 1));
  endtask

  task automatic wait_out(input int d, input int lat, input string nm);
    int k = 0;
    while (((d == 0) ? vld_a : vld_b) !== 1'b1 && k < 40) begin
      tick(); k++;
    end
    check({nm, "_latency"}, k, lat);
  endtask

  task automatic expect_out(input int d, input string nm, input logic [31:0] sd, input int cv,
                            input bit ex, input int zc);
    check({nm, "_data"},  (d == 0) ? sd_a : sd_b, sd);
    check({nm, "_count"}, (d == 0) ? 32'(cv_a) : 32'(cv_b), cv);
    check({nm, "_exact"}, (d == 0) ? ex_a : ex_b, ex);
    check({nm, "_zero"},  (d == 0) ? 32'(zc_a) : 32'(zc_b), zc);
  endtask

  task automatic ack(input int d, input string nm);
    rd = 1;
    tick();
    rd = 0;
    check({nm, "_ack_valid"}, (d == 0) ? vld_a : vld_b, 0);
    check({nm, "_ack_ready"}, (d == 0) ? rdy_a : rdy_b, 1);
  endtask

  initial begin
    reset = 1; en_a = 0; en_b = 0; valid = 0; data = 0; last = 0; rls = 0; rd = 0;
    model_clear(0); model_clear(1);
    #2 reset = 0;
    tick(); tick();
    check("rst_valid", vld_a, 0);
    check("rst_data",  sd_a,  0);
    check("rst_count", cv_a,  0);
    check("rst_exact", ex_b,  0);
    check("rst_zero",  zc_b,  0);
    reset = 1;
    #1;
    check("rst_ready_a", rdy_a, 1);
    check("rst_ready_b", rdy_b, 1);

    // Exact count with 8 entries; result 9 cycles after the last accept.
    q = '{5, 5, 3, 5, 7, 3, 5, 9};
    send_q(0, 1);
    wait_out(0, 9, "t1");
    expect_out(0, "t1", 5, 4, 1, 0);
    ack(0, "t1");

    // Eviction with 4 entries: the 5 replaces entry 0.
    q = '{1, 2, 3, 4, 5, 5};
    send_q(1, 1);
    wait_out(1, 5, "t2");
    expect_out(1, "t2", 5, 3, 0, 0);
    ack(1, "t2");

    // Tie goes to the lower index; outputs hold until acknowledged.
    q = '{2, 2, 6, 6};
    send_q(0, 1);
    wait_out(0, 9, "t3");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", vld_a, 1);
      check("t3_hold_data",  sd_a,  2);
      check("t3_hold_count", cv_a,  2);
    end
    ack(0, "t3");
    send(0, 6, 1);
    wait_out(0, 9, "t3b");
    expect_out(0, "t3b", 6, 1, 1, 0);
    ack(0, "t3b");

    // Implicit end at 16 samples, enable dropped between samples.
    for (int i = 0; i < 16; i++) begin
      send(1, 32'hA, 0);
      if (i < 15) begin
        valid = 1; data = 32'hA; en_b = 0;
        tick();
        valid = 0; data = 0;
      end
    end
    check("t4_ready_after_end", rdy_b, 0);
    wait_out(1, 5, "t4");
    check("t4_ready_in_out", rdy_b, 0);
    expect_out(1, "t4", 32'hA, 16, 1, 0);
    ack(1, "t4");

    // Release mid-block discards the partial 4,4,4.
    q = '{4, 4, 4};
    send_q(0, 0);
    rls = 1;
    tick();
    rls = 0;
    check("t5_rls_ready", rdy_a, 1);
    send(0, 7, 1);
    wait_out(0, 9, "t5");
    expect_out(0, "t5", 7, 1, 1, 0);
    ack(0, "t5");

    q = '{0, 0, 0, 4};
    send_q(0, 1);
    wait_out(0, 9, "t6");
`ifdef MFA_ZERO_SKIP_EN
    expect_out(0, "t6", 4, 1, 1, 3);
`else
    expect_out(0, "t6", 0, 3, 1, 0);
`endif
    ack(0, "t6");

    // Asynchronous reset while scanning.
    send(0, 1, 1);
    tick();
    check("t7_scan_ready", rdy_a, 0);
    #2 reset = 0;
    model_clear(0); model_clear(1);
    #1;
    check("t7_rst_ready", rdy_a, 1);
    check("t7_rst_valid", vld_a, 0);
    check("t7_rst_count", cv_a,  0);
    tick(); tick();
    reset = 1;
    for (int i = 0; i < 15; i++) tick();
    check("t7_no_result", vld_a, 0);
    send(0, 3, 1);
    wait_out(0, 9, "t7");
    expect_out(0, "t7", 3, 1, 1, 0);
    ack(0, "t7");

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
